// File: rtl/fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue.
package fetch_queue_pkg;

    localparam int FQ_DW    = 32;
    localparam int FQ_DEPTH = 4;
    localparam int FQ_AW    = 2;

    localparam logic [FQ_DW-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [FQ_DW-1:0] PC_RESET  = 32'h0000_0000;
    localparam logic [FQ_DW-1:0] PC_STEP   = 32'h0000_0004;

    // Sequential PC of the instruction following the one at pc.
    function automatic logic [FQ_DW-1:0] next_pc(input logic [FQ_DW-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side signals of the fetch queue.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int DW = FQ_DW,
    parameter int AW = FQ_AW
);
    logic          push_i;
    logic [DW-1:0] push_pc_i;
    logic [DW-1:0] push_instr_i;
    logic          pop_i;
    logic          flush_i;
    logic          pc_write_o;
    logic          ifid_valid_o;
    logic [DW-1:0] ifid_pc_o;
    logic [DW-1:0] ifid_pc4_o;
    logic [DW-1:0] ifid_instr_o;
    logic [AW:0]   count_o;

    // Fetch/decode side driving the queue.
    modport master (
        output push_i, push_pc_i, push_instr_i, pop_i, flush_i,
        input  pc_write_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, count_o
    );

    // The queue itself.
    modport slave (
        input  push_i, push_pc_i, push_instr_i, pop_i, flush_i,
        output pc_write_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, count_o
    );
endinterface

// File: rtl/fetch_queue_mem.sv
// DEPTH x (2*DW) register array holding {pc, instr} pairs;
// one synchronous write port, one combinational read port.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = FQ_AW,
    parameter int DW    = FQ_DW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [2*DW-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [2*DW-1:0] rdata_o
);

    logic [2*DW-1:0] mem_q [DEPTH];
    logic [2*DW-1:0] mem_d [DEPTH];

    // Next array contents: one entry replaced on a write.
    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between PC/instruction memory and decode.
// Buffers {pc, instr} pairs, holds the PC when full and drops
// everything on a branch/jump flush.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = FQ_AW,
    parameter int DW    = FQ_DW
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fetch_queue_if.slave bus
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q,  count_d;
    logic            push_acc_s;
    logic            pop_acc_s;
    logic [2*DW-1:0] head_s;
    logic            valid_s;

    // Flush dominates; a full queue never accepts a push even when popped.
    assign push_acc_s = bus.push_i && (count_q < DEPTH_C) && !bus.flush_i;
    assign pop_acc_s  = bus.pop_i  && (count_q != '0)     && !bus.flush_i;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (push_acc_s),
        .waddr_i (wr_ptr_q),
        .wdata_i ({bus.push_pc_i, bus.push_instr_i}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_s)
    );

    // Next pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_acc_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + (AW+1)'(push_acc_s) - (AW+1)'(pop_acc_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid_s = (count_q != '0);

    // Head presentation; an empty queue shows a NOP at PC 0.
    always_comb begin
        bus.ifid_pc_o    = '0;
        bus.ifid_pc4_o   = '0;
        bus.ifid_instr_o = '0;
        if (valid_s) begin
            bus.ifid_pc_o    = head_s[2*DW-1:DW];
            bus.ifid_pc4_o   = head_s[2*DW-1:DW] + DW'(PC_STEP);
            bus.ifid_instr_o = head_s[DW-1:0];
        end else begin
            bus.ifid_pc_o    = DW'(PC_RESET);
            bus.ifid_pc4_o   = DW'(PC_RESET);
            bus.ifid_instr_o = DW'(NOP_INSTR);
        end
    end

    assign bus.ifid_valid_o = valid_s;
    assign bus.count_o      = count_q;
    // Hold depends on registered count only, so decode's pop cannot loop back.
    assign bus.pc_write_o   = (count_q == DEPTH_C);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH 4, DW 32).
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    fetch_queue_if #(.DW(32), .AW(2)) bus ();

    fetch_queue #(.DEPTH(4), .AW(2), .DW(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.push_i = 1'b0; bus.pop_i = 1'b0; bus.flush_i = 1'b0;
        bus.push_pc_i = 32'h0; bus.push_instr_i = 32'h0;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] ins);
        bus.push_i = 1'b1; bus.push_pc_i = pc; bus.push_instr_i = ins;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        #3;
        checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count_o); end
        checks++; if (bus.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.ifid_valid_o); end
        checks++; if (bus.pc_write_o !== 1'b0) begin errors++; $display("FAIL reset_pc_write: got %b expected 0", bus.pc_write_o); end
        checks++; if (bus.ifid_pc_o !== 32'h0 || bus.ifid_pc4_o !== 32'h0 || bus.ifid_instr_o !== 32'h0) begin errors++; $display("FAIL reset_data: got pc=%h pc4=%h instr=%h expected all 0", bus.ifid_pc_o, bus.ifid_pc4_o, bus.ifid_instr_o); end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_fill3();
        apply_reset();
        bus.push_i = 1'b1; bus.push_pc_i = 32'h0; bus.push_instr_i = 32'h11;
        #1;
        checks++; if (bus.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL fill3_no_bypass: got valid=%b expected 0", bus.ifid_valid_o); end
        tick();
        checks++; if (bus.ifid_valid_o !== 1'b1 || bus.count_o !== 3'd1) begin errors++; $display("FAIL fill3_latency: got valid=%b count=%0d expected 1/1", bus.ifid_valid_o, bus.count_o); end
        bus.push_pc_i = 32'h4; bus.push_instr_i = 32'h22;
        tick();
        bus.push_pc_i = 32'h8; bus.push_instr_i = 32'h33;
        tick();
        idle();
        checks++; if (bus.count_o !== 3'd3) begin errors++; $display("FAIL fill3_count: got %0d expected 3", bus.count_o); end
        checks++; if (bus.ifid_pc_o !== 32'h0 || bus.ifid_instr_o !== 32'h11 || bus.ifid_pc4_o !== 32'h4) begin errors++; $display("FAIL fill3_head: got pc=%h instr=%h pc4=%h expected 0/11/4", bus.ifid_pc_o, bus.ifid_instr_o, bus.ifid_pc4_o); end
        checks++; if (bus.pc_write_o !== 1'b0) begin errors++; $display("FAIL fill3_pc_write: got %b expected 0", bus.pc_write_o); end
    endtask

    task automatic test_full();
        logic [31:0] exp_pc;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            push_one(32'(4 * i), 32'h100 + 32'(i));
            if (i == 2) begin
                checks++; if (bus.pc_write_o !== 1'b0) begin errors++; $display("FAIL full_pc_write_early: got %b expected 0", bus.pc_write_o); end
            end
            if (i == 3) begin
                checks++; if (bus.pc_write_o !== 1'b1) begin errors++; $display("FAIL full_pc_write: got %b expected 1", bus.pc_write_o); end
            end
        end
        checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL full_count_drop: got %0d expected 4", bus.count_o); end
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(4 * i);
            checks++; if (bus.ifid_valid_o !== 1'b1 || bus.ifid_pc_o !== exp_pc || bus.ifid_instr_o !== 32'h100 + 32'(i)) begin errors++; $display("FAIL full_pop_%0d: got valid=%b pc=%h instr=%h expected 1/%h/%h", i, bus.ifid_valid_o, bus.ifid_pc_o, bus.ifid_instr_o, exp_pc, 32'h100 + 32'(i)); end
            bus.pop_i = 1'b1;
            tick();
            idle();
        end
        checks++; if (bus.ifid_valid_o !== 1'b0 || bus.count_o !== 3'd0) begin errors++; $display("FAIL full_empty: got valid=%b count=%0d expected 0/0", bus.ifid_valid_o, bus.count_o); end
        checks++; if (bus.ifid_pc_o !== 32'h0 || bus.ifid_pc4_o !== 32'h0 || bus.ifid_instr_o !== 32'h0) begin errors++; $display("FAIL full_empty_data: got pc=%h pc4=%h instr=%h expected 0", bus.ifid_pc_o, bus.ifid_pc4_o, bus.ifid_instr_o); end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 0; i < 4; i++) push_one(32'h20 + 32'(4 * i), 32'h200 + 32'(i));
        bus.push_i = 1'b1; bus.pop_i = 1'b1; bus.push_pc_i = 32'h99; bus.push_instr_i = 32'hDEAD;
        tick();
        idle();
        checks++; if (bus.count_o !== 3'd3) begin errors++; $display("FAIL fpp_count: got %0d expected 3", bus.count_o); end
        checks++; if (bus.pc_write_o !== 1'b0) begin errors++; $display("FAIL fpp_pc_write: got %b expected 0", bus.pc_write_o); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (bus.ifid_pc_o !== 32'h20 + 32'(4 * i)) begin errors++; $display("FAIL fpp_head_%0d: got %h expected %h", i, bus.ifid_pc_o, 32'h20 + 32'(4 * i)); end
            bus.pop_i = 1'b1;
            tick();
            idle();
        end
        checks++; if (bus.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL fpp_dropped_push: got valid=%b pc=%h expected empty", bus.ifid_valid_o, bus.ifid_pc_o); end
    endtask

    task automatic test_flush();
        apply_reset();
        push_one(32'h0, 32'h11);
        push_one(32'h4, 32'h22);
        bus.push_i = 1'b1; bus.pop_i = 1'b1; bus.flush_i = 1'b1;
        bus.push_pc_i = 32'h50; bus.push_instr_i = 32'hBAD;
        tick();
        idle();
        checks++; if (bus.count_o !== 3'd0 || bus.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL flush_empty: got count=%0d valid=%b expected 0/0", bus.count_o, bus.ifid_valid_o); end
        push_one(32'h40, 32'hAA);
        checks++; if (bus.count_o !== 3'd1) begin errors++; $display("FAIL flush_refill_count: got %0d expected 1", bus.count_o); end
        checks++; if (bus.ifid_pc_o !== 32'h40 || bus.ifid_pc4_o !== 32'h44 || bus.ifid_instr_o !== 32'hAA) begin errors++; $display("FAIL flush_refill_head: got pc=%h pc4=%h instr=%h expected 40/44/aa", bus.ifid_pc_o, bus.ifid_pc4_o, bus.ifid_instr_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            bus.push_i = 1'b1; bus.pop_i = 1'b1;
            bus.push_pc_i = 32'h100 + 32'(4 * i); bus.push_instr_i = 32'h1000 + 32'(i);
            tick();
            exp_pc = 32'h100 + 32'(4 * i);
            checks++; if (bus.count_o !== 3'd1 || bus.ifid_pc_o !== exp_pc || bus.ifid_instr_o !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL stream_%0d: got count=%0d pc=%h instr=%h expected 1/%h/%h", i, bus.count_o, bus.ifid_pc_o, bus.ifid_instr_o, exp_pc, 32'h1000 + 32'(i)); end
        end
        idle();
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) push_one(32'h80 + 32'(4 * i), 32'h300 + 32'(i));
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.count_o !== 3'd0 || bus.ifid_valid_o !== 1'b0 || bus.pc_write_o !== 1'b0) begin errors++; $display("FAIL arst_mid3: got count=%0d valid=%b pc_write=%b expected 0/0/0", bus.count_o, bus.ifid_valid_o, bus.pc_write_o); end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) push_one(32'hC0 + 32'(4 * i), 32'h400 + 32'(i));
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.pc_write_o !== 1'b0 || bus.count_o !== 3'd0) begin errors++; $display("FAIL arst_full: got pc_write=%b count=%0d expected 0/0", bus.pc_write_o, bus.count_o); end
        tick();
        rst = 1'b1;
        bus.pop_i = 1'b1;
        tick();
        idle();
        checks++; if (bus.count_o !== 3'd0 || bus.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL arst_pop_empty: got count=%0d valid=%b expected 0/0", bus.count_o, bus.ifid_valid_o); end
        push_one(32'hE0, 32'h55);
        checks++; if (bus.count_o !== 3'd1 || bus.ifid_pc_o !== 32'hE0 || bus.ifid_pc4_o !== 32'hE4) begin errors++; $display("FAIL arst_first_push: got count=%0d pc=%h pc4=%h expected 1/e0/e4", bus.count_o, bus.ifid_pc_o, bus.ifid_pc4_o); end
    endtask

    initial begin
        idle();
        test_reset();
        test_fill3();
        test_full();
        test_full_push_pop();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
